delay_arbiter: RTL and testbench

DELAY_ARBITER -- requirements
Module: delay_arbiter

---
 rtl/delay_arbiter.sv | 154 +++++++++++++++
 tb/tb_delay_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : delay_arbiter
// Description : Round-robin arbiter sharing one prescaled delay timer among
//               three requesters; Moore outputs, all registered.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_arbiter #(
  parameter int N_REQ    = 3,
  parameter int PRESCALE = 19,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*CNT_W-1:0] dly_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic                   tick_o
);

  localparam int                 IDX_W      = 2;
  localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [7:0]         C_PS_MAX   = 8'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]   C_REM_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   win_q,   win_d;
  logic [IDX_W-1:0]   last_q,  last_d;
  logic [CNT_W-1:0]   rem_q,   rem_d;
  logic [7:0]         pcnt_q,  pcnt_d;
  logic [N_REQ-1:0]   gnt_q,   gnt_d;
  logic [N_REQ-1:0]   done_q,  done_d;
  logic               busy_q,  busy_d;
  logic               tick_q,  tick_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;
  logic [CNT_W-1:0]   dly_sel;

  // Search starts one past the last served index and wraps around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (cand == C_LAST_IDX) ? '0 : cand + IDX_W'(1);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    dly_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_q == IDX_W'(i)) begin
        dly_sel = dly_i[i*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    rem_d   = rem_q;
    pcnt_d  = pcnt_q;

    case (state_q)
      S_IDLE: begin
        pcnt_d = '0;
        if (pick_found) begin
          win_d   = pick_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        rem_d   = dly_sel;
        pcnt_d  = '0;
        state_d = (dly_sel == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (pcnt_q == C_PS_MAX) begin
          pcnt_d = '0;
          rem_d  = rem_q - C_REM_ONE;
          if (rem_q == C_REM_ONE) begin
            state_d = S_DONE;
          end
        end else begin
          pcnt_d = pcnt_q + 8'd1;
        end
      end
      S_DONE: begin
        pcnt_d  = '0;
        last_d  = win_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are computed from next-state values so the flops present
    // them in the same cycle the FSM occupies the corresponding state.
    busy_d = (state_d != S_IDLE);
    tick_d = (state_d == S_RUN) && (pcnt_d == C_PS_MAX);
    for (int i = 0; i < N_REQ; i++) begin
      gnt_d[i]  = (state_d != S_IDLE) && (win_d == IDX_W'(i));
      done_d[i] = (state_d == S_DONE) && (win_d == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      last_q  <= C_LAST_IDX;
      rem_q   <= '0;
      pcnt_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      pcnt_q  <= pcnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign tick_o = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_arbiter
// Description : Directed stimulus against a cycle-level reference model of
//               the delay arbiter, plus literal timing expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_arbiter;

  localparam int P = 19;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req   = 3'b000;
  logic [23:0] dly   = 24'd0;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        busy;
  logic        tick;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  int tick_c[$];
  int done_c[$];
  int done_v[$];
  int rise_c[$];
  int rise_v[$];
  int fall_c[$];
  logic [2:0] prev_gnt  = 3'b000;
  logic       prev_busy = 1'b0;

  bit m_srv  = 1'b0;
  int m_s    = 0;
  int m_n    = 0;
  int m_win  = 0;
  int m_last = 2;
  int m_end  = 0;

  delay_arbiter #(.N_REQ(3), .PRESCALE(P), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .dly_i  (dly),
    .gnt_o  (gnt),
    .done_o (done),
    .busy_o (busy),
    .tick_o (tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int dly_of(input int i);
    return int'(dly[i*8 +: 8]);
  endfunction

  function automatic int rr(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  // Reference model: a service started in IDLE cycle s lasts until s+2+N*P
  // (s+2 when N is 0), with ticks every P cycles counted from s+1.
  always @(negedge clk) begin
    logic [2:0] eg;
    logic [2:0] ed;
    logic       et;
    int         k;
    if (!rst_n) begin
      check("rst_gnt",  {29'd0, gnt},  32'd0);
      check("rst_done", {29'd0, done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_tick", {31'd0, tick}, 32'd0);
      m_srv     = 1'b0;
      m_last    = 2;
      prev_gnt  = 3'b000;
      prev_busy = 1'b0;
    end else begin
      eg = 3'b000;
      ed = 3'b000;
      et = 1'b0;
      if (m_srv) begin
        if (cyc == m_s + 1) m_n = dly_of(m_win);
        m_end = (m_n == 0) ? m_s + 2 : m_s + 2 + m_n * P;
        eg = 3'(1 << m_win);
        k  = cyc - m_s - 1;
        if (k > 0 && (k % P) == 0 && (k / P) <= m_n) et = 1'b1;
        if (cyc == m_end) ed = eg;
      end
      check("gnt",  {29'd0, gnt},  {29'd0, eg});
      check("done", {29'd0, done}, {29'd0, ed});
      check("tick", {31'd0, tick}, {31'd0, et});
      check("busy", {31'd0, busy}, {31'd0, m_srv});

      if (tick) tick_c.push_back(cyc);
      if (done != 3'b000) begin
        done_c.push_back(cyc);
        done_v.push_back(int'(done));
      end
      if (gnt != 3'b000 && prev_gnt == 3'b000) begin
        rise_c.push_back(cyc);
        rise_v.push_back(int'(gnt));
      end
      if (prev_busy && !busy) fall_c.push_back(cyc);
      prev_gnt  = gnt;
      prev_busy = busy;

      if (m_srv && cyc == m_end) begin
        m_srv  = 1'b0;
        m_last = m_win;
      end else if (!m_srv && req != 3'b000) begin
        m_srv = 1'b1;
        m_s   = cyc;
        m_win = rr(req, m_last);
        m_n   = 0;
      end
    end
  end

  task automatic clear_events();
    tick_c.delete();
    done_c.delete();
    done_v.delete();
    rise_c.delete();
    rise_v.delete();
    fall_c.delete();
  endtask

  task automatic run_req(input logic [2:0] r, input logic [23:0] d, output int t);
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (busy !== 1'b0 && guard < 200);
    if (guard >= 200) check("idle_timeout", {31'd0, busy}, 32'd0);
    clear_events();
    dly = d;
    req = r;
    t   = cyc;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int b;
    b = 0;
    while (done_c.size() < n && b < budget) begin
      @(posedge clk);
      #1;
      b++;
    end
    req = 3'b000;
    if (done_c.size() < n) check("done_timeout", done_c.size(), n);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = 3'b000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int t;
    int exp_v[5];
    exp_v = '{1, 2, 4, 1, 2};

    // Reset held with every requester asking
    rst_n = 1'b0;
    req   = 3'b111;
    dly   = {8'd3, 8'd3, 8'd3};
    repeat (4) @(posedge clk);
    #1;
    check("hold_rst_gnt",  {29'd0, gnt}, 32'd0);
    check("hold_rst_busy", {31'd0, busy}, 32'd0);
    req   = 3'b000;
    rst_n = 1'b1;

    // Single request, two ticks
    run_req(3'b001, {8'd0, 8'd0, 8'd2}, t);
    wait_dones(1, 100);
    repeat (3) @(posedge clk);
    #1;
    check("single_gnt_cyc",  (rise_c.size() > 0) ? rise_c[0] : -1, t + 1);
    check("single_gnt_val",  (rise_v.size() > 0) ? rise_v[0] : -1, 1);
    check("single_tick_n",   tick_c.size(), 2);
    check("single_tick0",    (tick_c.size() > 0) ? tick_c[0] : -1, t + 20);
    check("single_tick1",    (tick_c.size() > 1) ? tick_c[1] : -1, t + 39);
    check("single_done_n",   done_c.size(), 1);
    check("single_done_cyc", (done_c.size() > 0) ? done_c[0] : -1, t + 40);
    check("single_done_val", (done_v.size() > 0) ? done_v[0] : -1, 1);
    check("single_busy_off", (fall_c.size() > 0) ? fall_c[0] : -1, t + 41);

    // Zero delay
    run_req(3'b010, {8'd0, 8'd0, 8'd0}, t);
    wait_dones(1, 20);
    repeat (2) @(posedge clk);
    #1;
    check("zero_gnt_cyc",  (rise_c.size() > 0) ? rise_c[0] : -1, t + 1);
    check("zero_gnt_val",  (rise_v.size() > 0) ? rise_v[0] : -1, 2);
    check("zero_done_cyc", (done_c.size() > 0) ? done_c[0] : -1, t + 2);
    check("zero_done_val", (done_v.size() > 0) ? done_v[0] : -1, 2);
    check("zero_tick_n",   tick_c.size(), 0);

    // Fairness with all requesters held
    pulse_reset();
    run_req(3'b111, {8'd1, 8'd1, 8'd1}, t);
    wait_dones(5, 300);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("rr_order", (rise_v.size() > i) ? rise_v[i] : -1, exp_v[i]);
    end
    for (int i = 0; i < 4; i++) begin
      check("rr_spacing", (done_c.size() > i + 1) ? done_c[i+1] - done_c[i] : -1, P + 3);
    end
    check("rr_no_sixth", rise_c.size(), 5);

    // Abort by reset mid-delay
    run_req(3'b001, {8'd0, 8'd0, 8'd5}, t);
    repeat (31) @(posedge clk);
    #1;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    req   = 3'b000;
    #1;
    check("abort_gnt",  {29'd0, gnt},  32'd0);
    check("abort_done", {29'd0, done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_tick", {31'd0, tick}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_c.delete();
    repeat (200) @(posedge clk);
    #1;
    check("abort_no_done", done_c.size(), 0);

    // Early drop of req and late dly change
    run_req(3'b001, {8'd0, 8'd0, 8'd3}, t);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req = 3'b000;
    dly = {8'd0, 8'd0, 8'd9};
    wait_dones(1, 200);
    repeat (2) @(posedge clk);
    #1;
    check("drop_done_cyc", (done_c.size() > 0) ? done_c[0] : -1, t + 2 + 3 * P);
    check("drop_done_val", (done_v.size() > 0) ? done_v[0] : -1, 1);
    check("drop_tick_n",   tick_c.size(), 3);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
